// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list lowest-first, issuing one
// word access per listed register on a req/ack port, with optional base
// writeback after the last transfer.
// Optional build macro LDM_STM_PC_LOAD_EN adds the pc_loaded output, which
// flags a load of R15 so that fetch can flush and redirect.
module ldm_stm_sequencer #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic              up,
  input  logic              pre,
  input  logic              wback,
  input  logic [15:0]       reg_list,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        rf_read_num,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [3:0]        rf_write_num,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_regwrite
`ifdef LDM_STM_PC_LOAD_EN
  ,
  output logic              pc_loaded
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_WB, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       list_q, list_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] final_q, final_d;
  logic [3:0]        base_reg_q, base_reg_d;
  logic              load_q, load_d;
  logic              wb_q, wb_d;
  logic              req_q, req_d;
`ifdef LDM_STM_PC_LOAD_EN
  logic              pc_q, pc_d;
`endif

  logic [4:0]        count;
  logic [ADDR_W-1:0] stride, span, start_addr, end_addr;
  logic [15:0]       list_rest;
  logic [3:0]        cur_reg;

  function automatic logic [3:0] lowest_bit(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Register count and the first/final addresses for the requested mode
  always_comb begin
    count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      count = count + 5'(reg_list[i]);
    end
    stride = ADDR_W'(WORD_BYTES);
    span   = ADDR_W'(count) * stride;
    case ({up, pre})
      2'b10:   start_addr = base_addr;
      2'b11:   start_addr = base_addr + stride;
      2'b00:   start_addr = base_addr - span + stride;
      default: start_addr = base_addr - span;
    endcase
    end_addr = up ? (base_addr + span) : (base_addr - span);
  end

  // Current register is the lowest remaining bit; list_rest drops it
  always_comb begin
    list_rest = list_q & (list_q - 16'd1);
    cur_reg   = lowest_bit(list_q);
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      list_q     <= 16'd0;
      addr_q     <= '0;
      final_q    <= '0;
      base_reg_q <= 4'd0;
      load_q     <= 1'b0;
      wb_q       <= 1'b0;
      req_q      <= 1'b0;
`ifdef LDM_STM_PC_LOAD_EN
      pc_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      list_q     <= list_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
      base_reg_q <= base_reg_d;
      load_q     <= load_d;
      wb_q       <= wb_d;
      req_q      <= req_d;
`ifdef LDM_STM_PC_LOAD_EN
      pc_q       <= pc_d;
`endif
    end
  end

  // Next state: latch the command, then step one access per ack
  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    addr_d     = addr_q;
    final_d    = final_q;
    base_reg_d = base_reg_q;
    load_d     = load_q;
    wb_d       = wb_q;
    req_d      = req_q;
`ifdef LDM_STM_PC_LOAD_EN
    pc_d       = pc_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          list_d     = reg_list;
          addr_d     = start_addr;
          final_d    = end_addr;
          base_reg_d = base_reg;
          load_d     = is_load;
          wb_d       = wback && !(is_load && reg_list[base_reg]);
`ifdef LDM_STM_PC_LOAD_EN
          pc_d       = is_load && reg_list[15];
`endif
          if (count == 5'd0) begin
            state_d = ST_DONE;
            req_d   = 1'b0;
          end else begin
            state_d = ST_XFER;
            req_d   = 1'b1;
          end
        end
      end
      ST_XFER: begin
        if (req_q) begin
          if (mem_ack) begin
            list_d = list_rest;
            addr_d = addr_q + stride;
            req_d  = 1'b0;
            if (list_rest == 16'd0) begin
              state_d = wb_q ? ST_WB : ST_DONE;
            end
          end
        end else begin
          req_d = 1'b1;
        end
      end
      ST_WB:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; load write-back and store data follow the ack/RF combinationally
  always_comb begin
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    rf_read_num   = 4'd0;
    rf_write_num  = 4'd0;
    rf_write_data = '0;
    rf_regwrite   = 1'b0;
`ifdef LDM_STM_PC_LOAD_EN
    pc_loaded     = (state_q == ST_DONE) && pc_q;
`endif
    if (state_q == ST_XFER && req_q) begin
      mem_req  = 1'b1;
      mem_addr = addr_q;
      mem_we   = !load_q;
      if (!load_q) begin
        rf_read_num = cur_reg;
        mem_wdata   = rf_read_data;
      end else if (mem_ack) begin
        rf_regwrite   = 1'b1;
        rf_write_num  = cur_reg;
        rf_write_data = mem_rdata;
      end
    end else if (state_q == ST_WB) begin
      rf_regwrite   = 1'b1;
      rf_write_num  = base_reg_q;
      rf_write_data = DATA_W'(final_q);
    end
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed bench for ldm_stm_sequencer; expected values are hand-computed.
module tb_ldm_stm_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wback = 1'b0;
  logic [15:0] reg_list = 16'h0;
  logic [3:0]  base_reg = 4'h0;
  logic [31:0] base_addr = 32'h0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [3:0]  rf_read_num;
  logic [31:0] rf_read_data = 32'h0;
  logic [3:0]  rf_write_num;
  logic [31:0] rf_write_data;
  logic        rf_regwrite;
`ifdef LDM_STM_PC_LOAD_EN
  logic        pc_loaded;
`endif

  int n_vec = 0;
  int n_err = 0;

  ldm_stm_sequencer #(.ADDR_W(32), .DATA_W(32), .WORD_BYTES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .is_load(is_load), .up(up),
    .pre(pre), .wback(wback), .reg_list(reg_list), .base_reg(base_reg),
    .base_addr(base_addr), .busy(busy), .done(done), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rf_read_num(rf_read_num),
    .rf_read_data(rf_read_data), .rf_write_num(rf_write_num),
    .rf_write_data(rf_write_data), .rf_regwrite(rf_regwrite)
`ifdef LDM_STM_PC_LOAD_EN
    , .pc_loaded(pc_loaded)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: called at the negedge where the request is first visible
  task automatic access(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] num, input logic [31:0] data, input int waits);
    chk({tag, ".req"}, 32'(mem_req), 32'd1);
    chk({tag, ".addr"}, mem_addr, addr);
    chk({tag, ".we"}, 32'(mem_we), 32'(we));
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk({tag, ".req_hold"}, 32'(mem_req), 32'd1);
      chk({tag, ".addr_hold"}, mem_addr, addr);
      chk({tag, ".wr_wait"}, 32'(rf_regwrite), 32'd0);
    end
    if (we) begin
      chk({tag, ".rd_num"}, 32'(rf_read_num), 32'(num));
      rf_read_data = data;
      #1;
      chk({tag, ".wdata"}, mem_wdata, data);
    end else begin
      mem_rdata = data;
    end
    mem_ack = 1'b1;
    #1;
    chk({tag, ".regwrite"}, 32'(rf_regwrite), 32'(!we));
    if (!we) begin
      chk({tag, ".wr_num"}, 32'(rf_write_num), 32'(num));
      chk({tag, ".wr_data"}, rf_write_data, data);
    end
    @(negedge clock);
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    chk({tag, ".gap"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    // Reset state
    #2 reset = 1'b1;
    #1;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.req", 32'(mem_req), 32'd0);
    chk("rst.we", 32'(mem_we), 32'd0);
    chk("rst.addr", mem_addr, 32'h0);
    chk("rst.regwrite", 32'(rf_regwrite), 32'd0);
    chk("rst.wr_data", rf_write_data, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // LDMIA base 0x100, R0..R2, writeback to R9 = 0x10C, ack one cycle late
    start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1;
    reg_list = 16'h0007; base_reg = 4'd9; base_addr = 32'h100;
    @(negedge clock);
    start = 1'b0;
    chk("t1.busy", 32'(busy), 32'd1);
    access("t1.a0", 32'h100, 1'b0, 4'd0, 32'hA0A0_0000, 1);
    @(negedge clock);
    access("t1.a1", 32'h104, 1'b0, 4'd1, 32'hA1A1_1111, 1);
    @(negedge clock);
    access("t1.a2", 32'h108, 1'b0, 4'd2, 32'hA2A2_2222, 1);
    chk("t1.wb_we", 32'(rf_regwrite), 32'd1);
    chk("t1.wb_num", 32'(rf_write_num), 32'd9);
    chk("t1.wb_data", rf_write_data, 32'h10C);
    chk("t1.wb_done", 32'(done), 32'd0);
    @(negedge clock);
    chk("t1.done", 32'(done), 32'd1);
    chk("t1.done_busy", 32'(busy), 32'd1);
    chk("t1.done_we", 32'(rf_regwrite), 32'd0);
    @(negedge clock);
    chk("t1.idle_done", 32'(done), 32'd0);
    chk("t1.idle_busy", 32'(busy), 32'd0);

    // STMDB base 0x200, R0,R4,R15 at 0x1F4..0x1FC, zero-wait acks, WB R13 = 0x1F4
    start = 1'b1; is_load = 1'b0; up = 1'b0; pre = 1'b1; wback = 1'b1;
    reg_list = 16'h8011; base_reg = 4'd13; base_addr = 32'h200;
    @(negedge clock);
    start = 1'b0;
    access("t2.a0", 32'h1F4, 1'b1, 4'd0, 32'h5000_0000, 0);
    @(negedge clock);
    access("t2.a1", 32'h1F8, 1'b1, 4'd4, 32'h5000_0004, 0);
    @(negedge clock);
    access("t2.a2", 32'h1FC, 1'b1, 4'd15, 32'h5000_000F, 0);
    chk("t2.wb_we", 32'(rf_regwrite), 32'd1);
    chk("t2.wb_num", 32'(rf_write_num), 32'd13);
    chk("t2.wb_data", rf_write_data, 32'h1F4);
    @(negedge clock);
    chk("t2.done", 32'(done), 32'd1);
    @(negedge clock);
    chk("t2.idle", 32'(busy), 32'd0);

    // LDMIB base R3 in list {R3,R4}: loaded value wins, no WB cycle
    start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b1; wback = 1'b1;
    reg_list = 16'h0018; base_reg = 4'd3; base_addr = 32'h300;
    @(negedge clock);
    start = 1'b0;
    access("t3.a0", 32'h304, 1'b0, 4'd3, 32'h3333_3333, 1);
    @(negedge clock);
    access("t3.a1", 32'h308, 1'b0, 4'd4, 32'h4444_4444, 1);
    chk("t3.done", 32'(done), 32'd1);
    chk("t3.no_wb", 32'(rf_regwrite), 32'd0);
    @(negedge clock);
    chk("t3.idle", 32'(busy), 32'd0);

    // Empty list: straight to DONE, no access; start during DONE is ignored
    start = 1'b1; is_load = 1'b1; up = 1'b1; pre = 1'b0; wback = 1'b1;
    reg_list = 16'h0000; base_reg = 4'd1; base_addr = 32'h700;
    @(negedge clock);
    chk("t4.done", 32'(done), 32'd1);
    chk("t4.busy", 32'(busy), 32'd1);
    chk("t4.req", 32'(mem_req), 32'd0);
    chk("t4.we", 32'(rf_regwrite), 32'd0);
    reg_list = 16'h0001;
    @(negedge clock);
    start = 1'b0;
    chk("t4.ign_busy", 32'(busy), 32'd0);
    chk("t4.ign_done", 32'(done), 32'd0);
    @(negedge clock);
    chk("t4.ign_req", 32'(mem_req), 32'd0);
    chk("t4.ign_busy2", 32'(busy), 32'd0);

    // STMIA with a 5-cycle stall, then reset in the middle of the second access
    start = 1'b1; is_load = 1'b0; up = 1'b1; pre = 1'b0; wback = 1'b1;
    reg_list = 16'h0003; base_reg = 4'd5; base_addr = 32'h400;
    @(negedge clock);
    start = 1'b0;
    access("t5.a0", 32'h400, 1'b1, 4'd0, 32'h0BAD_0000, 5);
    @(negedge clock);
    chk("t5.a1_req", 32'(mem_req), 32'd1);
    chk("t5.a1_addr", mem_addr, 32'h404);
    chk("t5.a1_num", 32'(rf_read_num), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5.rst_busy", 32'(busy), 32'd0);
    chk("t5.rst_req", 32'(mem_req), 32'd0);
    chk("t5.rst_we", 32'(rf_regwrite), 32'd0);
    chk("t5.rst_addr", mem_addr, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("t5.post_busy", 32'(busy), 32'd0);
    chk("t5.post_we", 32'(rf_regwrite), 32'd0);

    // LDMDA base 0x500, {R1,R15} at 0x4FC,0x500, WB R2 = 0x4F8
    start = 1'b1; is_load = 1'b1; up = 1'b0; pre = 1'b0; wback = 1'b1;
    reg_list = 16'h8002; base_reg = 4'd2; base_addr = 32'h500;
    @(negedge clock);
    start = 1'b0;
    access("t6.a0", 32'h4FC, 1'b0, 4'd1, 32'h1111_0001, 0);
    @(negedge clock);
    access("t6.a1", 32'h500, 1'b0, 4'd15, 32'h0000_8000, 2);
    chk("t6.wb_we", 32'(rf_regwrite), 32'd1);
    chk("t6.wb_num", 32'(rf_write_num), 32'd2);
    chk("t6.wb_data", rf_write_data, 32'h4F8);
`ifdef LDM_STM_PC_LOAD_EN
    chk("t6.pc_wb", 32'(pc_loaded), 32'd0);
`endif
    @(negedge clock);
    chk("t6.done", 32'(done), 32'd1);
`ifdef LDM_STM_PC_LOAD_EN
    chk("t6.pc_done", 32'(pc_loaded), 32'd1);
`endif
    @(negedge clock);
    chk("t6.idle", 32'(done), 32'd0);
`ifdef LDM_STM_PC_LOAD_EN
    chk("t6.pc_idle", 32'(pc_loaded), 32'd0);
`endif

    // Stray ack while idle has no effect
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    chk("t7.we", 32'(rf_regwrite), 32'd0);
    @(negedge clock);
    mem_ack = 1'b0;
    chk("t7.busy", 32'(busy), 32'd0);
    chk("t7.req", 32'(mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
